// File: rtl/usb_rcv_pkg.sv
// Shared types and constants for the USB receive control unit.
package usb_rcv_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RCV_SYNC,
    CHECK_SYNC,
    RCV_BYTE,
    STORE,
    EOP_WAIT,
    DONE,
    ERR_WAIT,
    ERR_EOP,
    ERR_IDLE
  } rcv_state_t;

  localparam logic [7:0] USB_SYNC_BYTE = 8'h80;

endpackage

// File: rtl/usb_rcv_ctrl_if.sv
// Signal bundle between the receive controller and the timer / edge / EOP / FIFO blocks.
interface usb_rcv_ctrl_if #(
  parameter int unsigned LEN_W = 7
);

  logic             d_edge;
  logic             eop;
  logic             shift_enable;
  logic             byte_received;
  logic [7:0]       rcv_data;
  logic             fifo_full;
  logic             rcving;
  logic             w_enable;
  logic [7:0]       rcv_data_q;
  logic             r_error;
  logic             pkt_done;
  logic [LEN_W-1:0] pkt_len;

  // master is the controller; slave is the surrounding receiver datapath
  modport master (
    input  d_edge, eop, shift_enable, byte_received, rcv_data, fifo_full,
    output rcving, w_enable, rcv_data_q, r_error, pkt_done, pkt_len
  );

  modport slave (
    output d_edge, eop, shift_enable, byte_received, rcv_data, fifo_full,
    input  rcving, w_enable, rcv_data_q, r_error, pkt_done, pkt_len
  );

endinterface

// File: rtl/usb_rcv_ctrl.sv
// USB receive control: SYNC check, payload FIFO writes, length count, framing/overflow errors.
module usb_rcv_ctrl
  import usb_rcv_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = USB_SYNC_BYTE,
  parameter int unsigned MAX_BYTES = 64,
  parameter int unsigned LEN_W     = 7
) (
  input logic            clk,
  input logic            rst,
  usb_rcv_ctrl_if.master bus
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  rcv_state_t       r_state;
  logic [2:0]       r_bit_cnt;
  logic [LEN_W-1:0] r_byte_cnt;
  logic             r_rcving;
  logic             r_wen;
  logic [7:0]       r_data;
  logic             r_err;
  logic             r_pkt_done;
  logic [LEN_W-1:0] r_pkt_len;

  logic w_eop_se;
  assign w_eop_se = bus.eop & bus.shift_enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= 3'd0;
    end else if (bus.byte_received || !r_rcving) begin
      r_bit_cnt <= 3'd0;
    end else if (bus.shift_enable) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_byte_cnt <= '0;
      r_rcving   <= 1'b0;
      r_wen      <= 1'b0;
      r_data     <= 8'h00;
      r_err      <= 1'b0;
      r_pkt_done <= 1'b0;
      r_pkt_len  <= '0;
    end else begin
      r_wen      <= 1'b0;
      r_pkt_done <= 1'b0;
      if (bus.byte_received) r_data <= bus.rcv_data;
      unique case (r_state)
        IDLE, ERR_IDLE: begin
          if (bus.d_edge) begin
            r_state    <= RCV_SYNC;
            r_rcving   <= 1'b1;
            r_err      <= 1'b0;
            r_byte_cnt <= '0;
          end
        end
        RCV_SYNC: begin
          if (bus.byte_received)  r_state <= CHECK_SYNC;
          else if (w_eop_se)      r_state <= ERR_WAIT;
        end
        CHECK_SYNC: r_state <= (r_data == SYNC_BYTE) ? RCV_BYTE : ERR_WAIT;
        RCV_BYTE: begin
          // a completed byte wins over a coincident EOP sample
          if (bus.byte_received) r_state <= STORE;
          else if (w_eop_se)     r_state <= (r_bit_cnt == 3'd0) ? EOP_WAIT : ERR_WAIT;
        end
        STORE: begin
          if (!bus.fifo_full && (r_byte_cnt < MAX_LEN)) begin
            r_wen      <= 1'b1;
            r_byte_cnt <= r_byte_cnt + LEN_W'(1);
            r_state    <= RCV_BYTE;
          end else begin
            r_state <= ERR_WAIT;
          end
        end
        EOP_WAIT: begin
          if (bus.d_edge) begin
            r_state  <= DONE;
            r_rcving <= 1'b0;
          end
        end
        DONE: begin
          r_pkt_done <= 1'b1;
          r_pkt_len  <= r_byte_cnt;
          r_state    <= IDLE;
        end
        ERR_WAIT: if (w_eop_se) r_state <= ERR_EOP;
        ERR_EOP: begin
          if (bus.d_edge) begin
            r_state  <= ERR_IDLE;
            r_rcving <= 1'b0;
            r_err    <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rcving     = r_rcving;
  assign bus.w_enable   = r_wen;
  assign bus.rcv_data_q = r_data;
  assign bus.r_error    = r_err;
  assign bus.pkt_done   = r_pkt_done;
  assign bus.pkt_len    = r_pkt_len;

endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// Directed self-checking bench for usb_rcv_ctrl (MAX_BYTES reduced to 4 for the overflow case).
module tb_usb_rcv_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  usb_rcv_ctrl_if #(.LEN_W(7)) bus ();

  usb_rcv_ctrl #(
    .SYNC_BYTE(8'h80),
    .MAX_BYTES(4),
    .LEN_W    (7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Passive recorder of DUT strobes and their latency from the causing input.
  int         cyc      = 0;
  int         br_cyc   = 0;
  int         de_cyc   = 0;
  int         wen_lat  = 0;
  int         done_lat = 0;
  int         n_done   = 0;
  logic [7:0] wr_q[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.byte_received) br_cyc = cyc;
    if (bus.d_edge) de_cyc = cyc;
    if (bus.w_enable) begin
      wr_q.push_back(bus.rcv_data_q);
      wen_lat = cyc - br_cyc;
    end
    if (bus.pkt_done) begin
      n_done++;
      done_lat = cyc - de_cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bit slot: sample strobe, then a stray D+ edge that the FSM must ignore.
  task automatic send_bit(input bit last, input logic [7:0] b);
    bus.shift_enable  = 1'b1;
    bus.byte_received = last;
    if (last) bus.rcv_data = b;
    step();
    bus.shift_enable  = 1'b0;
    bus.byte_received = 1'b0;
    bus.d_edge        = 1'b1;
    step();
    bus.d_edge = 1'b0;
    step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(i == 7, b);
  endtask

  task automatic start_pkt(input string tag);
    bus.d_edge = 1'b1;
    step();
    bus.d_edge = 1'b0;
    check_eq(tag, 32'(bus.rcving), 32'd1);
  endtask

  task automatic end_pkt();
    bus.eop = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.shift_enable = 1'b1;
      step();
      bus.shift_enable = 1'b0;
      step();
      step();
    end
    bus.eop = 1'b0;
    step();
    bus.d_edge = 1'b1;
    step();
    bus.d_edge = 1'b0;
    repeat (4) step();
  endtask

  task automatic clear_log();
    wr_q.delete();
    n_done = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.d_edge        = 1'b0;
    bus.eop           = 1'b0;
    bus.shift_enable  = 1'b0;
    bus.byte_received = 1'b0;
    bus.rcv_data      = 8'h00;
    bus.fifo_full     = 1'b0;
    repeat (3) step();
    check_eq("rst_rcving", 32'(bus.rcving), 32'd0);
    check_eq("rst_wen", 32'(bus.w_enable), 32'd0);
    check_eq("rst_err", 32'(bus.r_error), 32'd0);
    check_eq("rst_done", 32'(bus.pkt_done), 32'd0);
    check_eq("rst_len", 32'(bus.pkt_len), 32'd0);
    check_eq("rst_data", 32'(bus.rcv_data_q), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // 1: good packet
    clear_log();
    start_pkt("t1_rcving");
    send_byte(8'h80);
    send_byte(8'hA5);
    send_byte(8'h3C);
    end_pkt();
    check_eq("t1_nwr", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() == 2) begin
      check_eq("t1_wr0", 32'(wr_q[0]), 32'hA5);
      check_eq("t1_wr1", 32'(wr_q[1]), 32'h3C);
    end
    check_eq("t1_wen_lat", 32'(wen_lat), 32'd2);
    check_eq("t1_ndone", 32'(n_done), 32'd1);
    check_eq("t1_done_lat", 32'(done_lat), 32'd2);
    check_eq("t1_len", 32'(bus.pkt_len), 32'd2);
    check_eq("t1_err", 32'(bus.r_error), 32'd0);
    check_eq("t1_idle", 32'(bus.rcving), 32'd0);

    // 2: bad sync, then recovery with a 1-byte packet
    clear_log();
    start_pkt("t2_rcving");
    send_byte(8'h81);
    send_byte(8'h11);
    send_byte(8'h22);
    end_pkt();
    check_eq("t2_nwr", 32'(wr_q.size()), 32'd0);
    check_eq("t2_err", 32'(bus.r_error), 32'd1);
    check_eq("t2_rcving", 32'(bus.rcving), 32'd0);
    check_eq("t2_ndone", 32'(n_done), 32'd0);
    start_pkt("t2b_rcving");
    check_eq("t2_err_clr", 32'(bus.r_error), 32'd0);
    send_byte(8'h80);
    send_byte(8'h5A);
    end_pkt();
    check_eq("t2b_len", 32'(bus.pkt_len), 32'd1);
    check_eq("t2b_ndone", 32'(n_done), 32'd1);

    // 3: partial byte before EOP
    clear_log();
    start_pkt("t3_rcving");
    send_byte(8'h80);
    send_byte(8'h77);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 8'h00);
    end_pkt();
    check_eq("t3_nwr", 32'(wr_q.size()), 32'd1);
    check_eq("t3_err", 32'(bus.r_error), 32'd1);
    check_eq("t3_ndone", 32'(n_done), 32'd0);

    // 4: overflow at MAX_BYTES = 4
    clear_log();
    start_pkt("t4_rcving");
    send_byte(8'h80);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i));
    end_pkt();
    check_eq("t4_nwr", 32'(wr_q.size()), 32'd4);
    if (wr_q.size() == 4) check_eq("t4_wr3", 32'(wr_q[3]), 32'h43);
    check_eq("t4_err", 32'(bus.r_error), 32'd1);
    check_eq("t4_ndone", 32'(n_done), 32'd0);
    check_eq("t4_len_held", 32'(bus.pkt_len), 32'd1);

    // 5: FIFO full on the second payload byte
    clear_log();
    start_pkt("t5_rcving");
    send_byte(8'h80);
    send_byte(8'hC1);
    bus.fifo_full = 1'b1;
    send_byte(8'hC2);
    bus.fifo_full = 1'b0;
    end_pkt();
    check_eq("t5_nwr", 32'(wr_q.size()), 32'd1);
    check_eq("t5_err", 32'(bus.r_error), 32'd1);
    check_eq("t5_ndone", 32'(n_done), 32'd0);

    // 6: reset mid-packet, then a clean 1-byte packet
    clear_log();
    start_pkt("t6_rcving");
    send_byte(8'h80);
    send_byte(8'hE7);
    check_eq("t6_pre_nwr", 32'(wr_q.size()), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_rcving", 32'(bus.rcving), 32'd0);
    check_eq("t6_rst_len", 32'(bus.pkt_len), 32'd0);
    check_eq("t6_rst_data", 32'(bus.rcv_data_q), 32'd0);
    check_eq("t6_rst_err", 32'(bus.r_error), 32'd0);
    step();
    rst = 1'b0;
    step();
    clear_log();
    start_pkt("t6b_rcving");
    send_byte(8'h80);
    send_byte(8'h9D);
    end_pkt();
    check_eq("t6_nwr", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() == 1) check_eq("t6_wr0", 32'(wr_q[0]), 32'h9D);
    check_eq("t6_len", 32'(bus.pkt_len), 32'd1);
    check_eq("t6_ndone", 32'(n_done), 32'd1);
    check_eq("t6_err", 32'(bus.r_error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
